// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit:
// opcodes, control-bus field values, FSM states and the bus bundle.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;

    localparam logic [1:0] BR_SEQ  = 2'b01;
    localparam logic [1:0] BR_COND = 2'b11;
    localparam logic [1:0] BR_JALR = 2'b10;

    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_MEM = 2'b01;
    localparam logic [1:0] WSEL_PC4 = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_ILL
    } opc_t;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
        logic [1:0] branch;
        logic [1:0] reg_write_sel;
        logic       trap;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        imem_req: 1'b0, ir_write: 1'b0, pc_write: 1'b0,
        mem_read: 1'b0, mem_write: 1'b0, alu_src: 1'b0,
        reg_write: 1'b0, alu_op: ALU_ADD, branch: BR_SEQ,
        reg_write_sel: WSEL_ALU, trap: 1'b0
    };

    function automatic opc_t opc_class(input logic [6:0] op);
        case (op)
            OP_R:      return C_R;
            OP_I:      return C_I;
            OP_LOAD:   return C_LOAD;
            OP_STORE:  return C_STORE;
            OP_BRANCH: return C_BRANCH;
            OP_JAL:    return C_JAL;
            OP_JALR:   return C_JALR;
            default:   return C_ILL;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decoder from FSM state and latched opcode class
// to the datapath control bus.
module ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  state_t state,
    input  opc_t   opc,
    input  logic   run,
    input  logic   imem_ready,
    input  logic   dmem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = CTRL_IDLE;
        // ALU and branch selects stay stable from EXEC through WB
        if (state inside {S_EXEC, S_MEM, S_WB}) begin
            case (opc)
                C_R:      ctrl.alu_op = ALU_R;
                C_I: begin
                    ctrl.alu_op  = ALU_I;
                    ctrl.alu_src = 1'b1;
                end
                C_LOAD, C_STORE, C_JALR: ctrl.alu_src = 1'b1;
                C_BRANCH: ctrl.alu_op = ALU_BR;
                default: ;
            endcase
            case (opc)
                C_BRANCH, C_JAL: ctrl.branch = BR_COND;
                C_JALR:          ctrl.branch = BR_JALR;
                default: ;
            endcase
        end
        unique case (state)
            S_FETCH: begin
                ctrl.imem_req = run;
                ctrl.ir_write = run & imem_ready;
            end
            S_EXEC: ctrl.pc_write = (opc == C_BRANCH);
            S_MEM: begin
                ctrl.mem_read  = (opc == C_LOAD);
                ctrl.mem_write = (opc == C_STORE);
                ctrl.pc_write  = (opc == C_STORE) & dmem_ready;
            end
            S_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.pc_write  = 1'b1;
                case (opc)
                    C_LOAD:         ctrl.reg_write_sel = WSEL_MEM;
                    C_JAL, C_JALR:  ctrl.reg_write_sel = WSEL_PC4;
                    default:        ctrl.reg_write_sel = WSEL_ALU;
                endcase
            end
            S_TRAP: ctrl.trap = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb
// over ready handshakes and counts retired instructions.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src,
    output logic             reg_write,
    output logic [1:0]       alu_op,
    output logic [1:0]       branch,
    output logic [1:0]       reg_write_sel,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    state_t state, state_nxt;
    opc_t   opc_q, opc_dec;
    ctrl_t  dec, ctrl;

    assign opc_dec = opc_class(opcode);

    ctrl_decode u_dec (
        .state      (state),
        .opc        (opc_q),
        .run        (run),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .ctrl       (dec)
    );

    // Reset masks the bus in the same cycle, regardless of state
    assign ctrl = rst_n ? dec : CTRL_IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            opc_q   <= C_R;
            instret <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) opc_q <= opc_dec;
            if (ctrl.pc_write) instret <= instret + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_FETCH:  if (run && imem_ready) state_nxt = S_DECODE;
            S_DECODE: state_nxt = (opc_dec == C_ILL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (opc_q)
                    C_BRANCH:        state_nxt = S_FETCH;
                    C_LOAD, C_STORE: state_nxt = S_MEM;
                    default:         state_nxt = S_WB;
                endcase
            end
            S_MEM: if (dmem_ready)
                state_nxt = (opc_q == C_LOAD) ? S_WB : S_FETCH;
            S_WB:     state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_FETCH;
        endcase
    end

    assign imem_req      = ctrl.imem_req;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign alu_src       = ctrl.alu_src;
    assign reg_write     = ctrl.reg_write;
    assign alu_op        = ctrl.alu_op;
    assign branch        = ctrl.branch;
    assign reg_write_sel = ctrl.reg_write_sel;
    assign trap          = ctrl.trap;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; a second CNT_W=4 instance
// shares the stimulus to exercise counter wrap.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, run, imem_ready, dmem_ready;
    logic [6:0] opcode;

    logic a_req, a_irw, a_pcw, a_mr, a_mw, a_src, a_rw, a_trap;
    logic [1:0] a_aop, a_br, a_ws;
    logic [31:0] a_cnt;
    logic b_req, b_irw, b_pcw, b_mr, b_mw, b_src, b_rw, b_trap;
    logic [1:0] b_aop, b_br, b_ws;
    logic [3:0] b_cnt;

    int ncmp = 0;
    int nerr = 0;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ILL    = 7'b1111111;

    // {req,irw,pcw,mr,mw,src,rw}_aluop_branch_wsel_trap
    localparam logic [13:0] IDLE    = 14'b0000000_00_01_00_0;
    localparam logic [13:0] F_HIT   = 14'b1100000_00_01_00_0;
    localparam logic [13:0] F_WAIT  = 14'b1000000_00_01_00_0;
    localparam logic [13:0] LS_EX   = 14'b0000010_00_01_00_0;
    localparam logic [13:0] ST_MEM  = 14'b0000110_00_01_00_0;
    localparam logic [13:0] ST_RDY  = 14'b0010110_00_01_00_0;
    localparam logic [13:0] LD_MEM  = 14'b0001010_00_01_00_0;
    localparam logic [13:0] LD_WB   = 14'b0010001_00_01_01_0;
    localparam logic [13:0] ADD_EX  = 14'b0000000_10_01_00_0;
    localparam logic [13:0] ADD_WB  = 14'b0010001_10_01_00_0;
    localparam logic [13:0] BR_EX   = 14'b0010000_01_11_00_0;
    localparam logic [13:0] I_EX    = 14'b0000010_11_01_00_0;
    localparam logic [13:0] I_WB    = 14'b0010001_11_01_00_0;
    localparam logic [13:0] JAL_EX  = 14'b0000000_00_11_00_0;
    localparam logic [13:0] JAL_WB  = 14'b0010001_00_11_10_0;
    localparam logic [13:0] JALR_EX = 14'b0000010_00_10_00_0;
    localparam logic [13:0] JALR_WB = 14'b0010011_00_10_10_0;
    localparam logic [13:0] TRAPV   = 14'b0000000_00_01_00_1;
    localparam logic [13:0] FULL    = 14'b1111111_11_11_11_1;
    localparam logic [13:0] NOALU   = 14'b1111101_00_11_11_1;
    localparam logic [13:0] NOSRC   = 14'b1111101_11_11_11_1;

    wire [13:0] a_bus = {a_req, a_irw, a_pcw, a_mr, a_mw, a_src, a_rw,
                         a_aop, a_br, a_ws, a_trap};
    wire [13:0] b_bus = {b_req, b_irw, b_pcw, b_mr, b_mw, b_src, b_rw,
                         b_aop, b_br, b_ws, b_trap};

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(a_req), .ir_write(a_irw), .pc_write(a_pcw),
        .mem_read(a_mr), .mem_write(a_mw), .alu_src(a_src),
        .reg_write(a_rw), .alu_op(a_aop), .branch(a_br),
        .reg_write_sel(a_ws), .trap(a_trap), .instret(a_cnt)
    );

    multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(b_req), .ir_write(b_irw), .pc_write(b_pcw),
        .mem_read(b_mr), .mem_write(b_mw), .alu_src(b_src),
        .reg_write(b_rw), .alu_op(b_aop), .branch(b_br),
        .reg_write_sel(b_ws), .trap(b_trap), .instret(b_cnt)
    );

    task automatic chk_bus(input string tag, input logic [13:0] exp,
                           input logic [13:0] care);
        ncmp++;
        assert ((a_bus & care) === (exp & care)) else begin
            nerr++;
            $error("FAIL %s: bus=%b expected %b", tag, a_bus & care, exp & care);
        end
        ncmp++;
        assert ((b_bus & care) === (exp & care)) else begin
            nerr++;
            $error("FAIL %s(w4): bus=%b expected %b", tag, b_bus & care, exp & care);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] exp_a,
                           input logic [3:0] exp_b);
        ncmp++;
        assert (a_cnt === exp_a) else begin
            nerr++;
            $error("FAIL %s: instret=%0d expected %0d", tag, a_cnt, exp_a);
        end
        ncmp++;
        assert (b_cnt === exp_b) else begin
            nerr++;
            $error("FAIL %s(w4): instret=%0d expected %0d", tag, b_cnt, exp_b);
        end
    endtask

    task automatic drive(input logic r, input logic [6:0] op,
                         input logic ir, input logic dr);
        run        = r;
        opcode     = op;
        imem_ready = ir;
        dmem_ready = dr;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, OP_R, 1'b0, 1'b0);
        chk_bus("rst_idle", IDLE, FULL);
        adv(); adv();
        rst_n = 1'b1;

        // store parked in MEM, then reset hits mid-access
        drive(1'b1, OP_STORE, 1'b1, 1'b0); chk_bus("st_fetch", F_HIT, FULL); adv();
        drive(1'b1, OP_STORE, 1'b0, 1'b0); chk_bus("st_decode", IDLE, FULL); adv();
        drive(1'b1, OP_STORE, 1'b0, 1'b0); chk_bus("st_exec", LS_EX, FULL); adv();
        drive(1'b1, OP_STORE, 1'b0, 1'b0); chk_bus("st_mem", ST_MEM, FULL);
        rst_n = 1'b0; #1;
        chk_bus("rst_in_mem", IDLE, FULL);
        adv(); adv();
        chk_cnt("rst_instret", 32'd0, 4'd0);
        rst_n = 1'b1;
        drive(1'b0, OP_R, 1'b0, 1'b0); chk_bus("post_rst_park", IDLE, FULL); adv();

        // zero-wait ADD
        drive(1'b1, OP_R, 1'b1, 1'b0); chk_bus("add_fetch", F_HIT, FULL); adv();
        drive(1'b1, OP_R, 1'b1, 1'b1); chk_bus("add_decode", IDLE, FULL); adv();
        drive(1'b1, OP_R, 1'b0, 1'b0); chk_bus("add_exec", ADD_EX, FULL); adv();
        drive(1'b1, OP_R, 1'b0, 1'b0); chk_bus("add_wb", ADD_WB, NOALU); adv();
        chk_cnt("add_instret", 32'd1, 4'd1);

        // LOAD with three dmem wait cycles; opcode input changes after DECODE
        drive(1'b1, OP_LOAD, 1'b1, 1'b0); chk_bus("ld_fetch", F_HIT, FULL); adv();
        drive(1'b1, OP_LOAD, 1'b0, 1'b0); chk_bus("ld_decode", IDLE, FULL); adv();
        drive(1'b1, OP_ILL, 1'b0, 1'b0); chk_bus("ld_exec", LS_EX, FULL); adv();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_ILL, 1'b1, 1'b0); chk_bus("ld_mem_wait", LD_MEM, FULL); adv();
        end
        drive(1'b1, OP_ILL, 1'b0, 1'b1); chk_bus("ld_mem_rdy", LD_MEM, FULL); adv();
        drive(1'b1, OP_ILL, 1'b0, 1'b0); chk_bus("ld_wb", LD_WB, NOALU); adv();
        chk_cnt("ld_instret", 32'd2, 4'd2);

        // BRANCH then STORE back to back
        drive(1'b1, OP_BRANCH, 1'b1, 1'b0); chk_bus("br_fetch", F_HIT, FULL); adv();
        drive(1'b1, OP_BRANCH, 1'b0, 1'b0); chk_bus("br_decode", IDLE, FULL); adv();
        drive(1'b1, OP_BRANCH, 1'b0, 1'b1); chk_bus("br_exec", BR_EX, FULL); adv();
        drive(1'b1, OP_STORE, 1'b1, 1'b0); chk_bus("st2_fetch", F_HIT, FULL); adv();
        drive(1'b1, OP_STORE, 1'b0, 1'b0); chk_bus("st2_decode", IDLE, FULL); adv();
        drive(1'b1, OP_STORE, 1'b0, 1'b0); chk_bus("st2_exec", LS_EX, FULL); adv();
        drive(1'b1, OP_STORE, 1'b0, 1'b0); chk_bus("st2_mem_wait", ST_MEM, FULL); adv();
        drive(1'b1, OP_STORE, 1'b0, 1'b1); chk_bus("st2_mem_rdy", ST_RDY, FULL); adv();
        drive(1'b1, OP_STORE, 1'b0, 1'b0); chk_bus("st2_refetch", F_WAIT, FULL); adv();
        chk_cnt("brst_instret", 32'd4, 4'd4);

        // I-type with run dropped mid-EXEC: completes, then parks
        drive(1'b1, OP_I, 1'b1, 1'b0); chk_bus("i_fetch", F_HIT, FULL); adv();
        drive(1'b1, OP_I, 1'b0, 1'b0); chk_bus("i_decode", IDLE, FULL); adv();
        drive(1'b0, OP_I, 1'b0, 1'b0); chk_bus("i_exec", I_EX, FULL); adv();
        drive(1'b0, OP_I, 1'b0, 1'b0); chk_bus("i_wb", I_WB, NOALU); adv();
        drive(1'b0, OP_I, 1'b1, 1'b0); chk_bus("park0", IDLE, FULL); adv();
        drive(1'b0, OP_I, 1'b1, 1'b0); chk_bus("park1", IDLE, FULL); adv();
        chk_cnt("i_instret", 32'd5, 4'd5);

        // JAL and JALR
        drive(1'b1, OP_JAL, 1'b1, 1'b0); chk_bus("jal_fetch", F_HIT, FULL); adv();
        drive(1'b1, OP_JAL, 1'b0, 1'b0); chk_bus("jal_decode", IDLE, FULL); adv();
        drive(1'b1, OP_JAL, 1'b0, 1'b0); chk_bus("jal_exec", JAL_EX, NOSRC); adv();
        drive(1'b1, OP_JAL, 1'b0, 1'b0); chk_bus("jal_wb", JAL_WB, NOSRC); adv();
        drive(1'b1, OP_JALR, 1'b1, 1'b0); chk_bus("jalr_fetch", F_HIT, FULL); adv();
        drive(1'b1, OP_JALR, 1'b0, 1'b0); chk_bus("jalr_decode", IDLE, FULL); adv();
        drive(1'b1, OP_JALR, 1'b0, 1'b0); chk_bus("jalr_exec", JALR_EX, FULL); adv();
        drive(1'b1, OP_JALR, 1'b0, 1'b0); chk_bus("jalr_wb", JALR_WB, NOSRC); adv();
        chk_cnt("jmp_instret", 32'd7, 4'd7);

        // nine branches take the narrow counter through 15 -> 0
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, OP_BRANCH, 1'b1, 1'b0); chk_bus("wrap_fetch", F_HIT, FULL); adv();
            drive(1'b1, OP_BRANCH, 1'b0, 1'b0); chk_bus("wrap_decode", IDLE, FULL); adv();
            drive(1'b1, OP_BRANCH, 1'b0, 1'b0); chk_bus("wrap_exec", BR_EX, FULL); adv();
            chk_cnt("wrap_instret", 32'(8 + k), 4'((8 + k) % 16));
        end

        // illegal opcode: sticky trap, no strobes, count frozen
        drive(1'b1, OP_ILL, 1'b1, 1'b0); chk_bus("ill_fetch", F_HIT, FULL); adv();
        drive(1'b1, OP_ILL, 1'b0, 1'b0); chk_bus("ill_decode", IDLE, FULL); adv();
        for (int t = 0; t < 20; t++) begin
            drive(1'b1, OP_R, 1'b1, 1'b1); chk_bus("trap_sticky", TRAPV, FULL); adv();
        end
        chk_cnt("trap_instret", 32'd16, 4'd0);
        rst_n = 1'b0; #1;
        chk_bus("trap_rst", IDLE, FULL);
        adv();
        rst_n = 1'b1;
        drive(1'b1, OP_R, 1'b0, 1'b0); chk_bus("trap_cleared", F_WAIT, FULL);
        chk_cnt("trap_rst_instret", 32'd0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I datapath. It fills the control-unit slot of the core and sequences fetch, decode, execute, memory and writeback over several clocks, so imem/dmem can have variable latency through ready handshakes. It drives the existing datapath control bus (ALUOp, ALUSrc, Branch, RegWriteSel, MemRead/MemWrite, RegWrite), plus ir_write/pc_write strobes and a retired-instruction counter.

Parameters:
CNT_W, 32, width of instret counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
run  in  1  allow new fetches; sampled only in FETCH
opcode  in  7  INS[6:0] from instruction register
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access completes this cycle
imem_req  out  1  instruction fetch request
ir_write  out  1  load instruction register
pc_write  out  1  commit INS_ADDR_IN into PC
mem_read  out  1  dmem read enable
mem_write  out  1  dmem write enable
alu_src  out  1  0=rs2, 1=immediate
reg_write  out  1  register file write enable
alu_op  out  2  00 add, 01 branch compare, 10 R-type, 11 I-type ALU
branch  out  2  01 sequential, 11 conditional/JAL, 10 JALR
reg_write_sel  out  2  00 ALU, 01 DMEM, 10 PC+4
trap  out  1  sticky illegal-opcode flag
instret  out  CNT_W  retired instruction count

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Opcode class is latched into opc_q in DECODE.
- Reset: state=FETCH, opc_q=0, instret=0, trap=0. While rst_n=0, every strobe (imem_req, ir_write, pc_write, mem_read, mem_write, reg_write) is forced to 0 in the same cycle, whatever the current state. alu_op=00, alu_src=0, branch=01, reg_write_sel=00.
- Outputs are Moore-style, decoded from state and opc_q. Exception: ir_write = FETCH & imem_ready.
- FETCH:
  - run=0: imem_req=0, stay.
  - run=1: imem_req=1. On imem_ready=1, ir_write=1 and go to DECODE. Otherwise hold.
- DECODE (1 cycle):
  - Latch opcode.
  - Legal opcodes: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR. These go to EXEC.
  - Any other opcode goes to TRAP.
- EXEC (1 cycle), per class:
  - R: alu_op=10, alu_src=0.
  - I: alu_op=11, alu_src=1.
  - LOAD/STORE: alu_op=00, alu_src=1.
  - BRANCH: alu_op=01, alu_src=0, branch=11, pc_write=1, then go to FETCH.
  - JAL: branch=11. JALR: alu_op=00, alu_src=1, branch=10.
- Next state from EXEC: LOAD/STORE go to MEM; all other non-branch classes go to WB.
- MEM:
  - mem_read (LOAD) or mem_write (STORE) is held with stable alu_op/alu_src until dmem_ready=1.
  - On the ready cycle, LOAD goes to WB.
  - STORE asserts pc_write=1 on the ready cycle and goes to FETCH.
- WB (1 cycle):
  - reg_write=1 and pc_write=1, then go to FETCH.
  - reg_write_sel: 00 for R/I, 01 for LOAD, 10 for JAL/JALR.
  - branch: 01 for R/I/LOAD; JAL/JALR branch and alu_op are held from EXEC.
- Latency, assuming zero-wait memories: BRANCH 3 cycles; R/I/STORE/JAL/JALR 4; LOAD 5. Each wait cycle adds 1.
- pc_write pulses exactly once per retired instruction. instret increments on every cycle with pc_write=1 and wraps 2^CNT_W-1 -> 0 with no flag.
- TRAP: trap=1, all strobes 0, stay until reset. The trapped instruction is not counted.
- run=0 mid-instruction has no effect; the instruction completes and the FSM parks in FETCH.
- imem_ready outside FETCH and dmem_ready outside MEM are ignored.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants
  - ALUOp, Branch and RegWriteSel encodings
  - state enum
- One natural sub-module: ctrl_decode, a combinational state+opc_q -> control-bus decoder. Keep the FSM and counter in multicycle_ctrl.

Test Plan:
- rst_n=0 for 2 cycles, with the FSM in MEM and mem_write=1 before reset -> the same cycle all strobes read 0; after release, state=FETCH, instret=0, trap=0.
- Zero-wait ADD (opcode 0110011), run=1 -> imem_req in cycle 0, WB in cycle 3 with reg_write=1, reg_write_sel=00, pc_write=1; instret=1.
- LOAD with dmem_ready low for 3 cycles -> mem_read held 4 cycles; WB reg_write_sel=01; 8 cycles total; exactly one pc_write.
- BRANCH then STORE back-to-back -> BRANCH pc_write in cycle 2 with branch=11, alu_op=01; STORE commits on dmem_ready with reg_write never 1; instret=2.
- Opcode 1111111 -> TRAP after DECODE, trap=1 sticky for 20 cycles, no strobes, instret unchanged; rst_n clears it.
- CNT_W=4: retire 16 instructions -> instret wraps 15 -> 0. Drop run mid-EXEC -> the instruction retires and imem_req stays 0.
